dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the MEM-stage data interface (d_read_en/d_write_en/d_addr/d_write_data/d_data_in).
//  Serves word RAM reads/writes and a memory-mapped UART TX FIFO, and drains the FIFO over a valid/ready byte port.
//  Asserts pstop_o to freeze the pipeline when a TX write hits a full FIFO.
//  Sits between the MEM stage, the pipeline stall logic and the UART transmitter.
// PARAMETERS
//  RAM_AW     10             RAM word-address width; RAM holds 2**RAM_AW 32-bit words at byte addr 0..4*2**RAM_AW-1
//  MMIO_BASE  32'hFFFF_0000  base byte address of the MMIO window (64 KiB, compared on d_addr[31:16])
//  TX_DEPTH   4              TX FIFO depth in bytes; power of 2, >=2
// PORTS
//  clk           in   1   clock, all state updates on posedge
//  rst           in   1   synchronous active-high reset
//  d_read_en     in   1   read strobe from MEM stage
//  d_write_en    in   1   write strobe from MEM stage
//  d_addr        in   32  byte address
//  d_write_data  in   32  store data
//  d_data_out    out  32  load data, combinational, consumed by MEM stage as d_data_in in the same cycle
//  pstop_o       out  1   pipeline stall request, combinational
//  tx_data       out  8   byte at FIFO head
//  tx_valid      out  1   FIFO not empty
//  tx_ready      in   1   UART TX accepts byte; pop when tx_valid && tx_ready
//  align_err_o   out  1   only when DMEM_ALIGN_CHECK_EN is defined
// BEHAVIOUR
//  Decode: ram_sel = d_addr < 4*2**RAM_AW; mmio_sel = d_addr[31:16]==MMIO_BASE[31:16]; else unmapped.
//  RAM: word index d_addr[RAM_AW+1:2]; asynchronous read; write at posedge when d_write_en && ram_sel.
//  RAM contents are not touched by rst.
//  MMIO +0x0 TXDATA: write pushes d_write_data[7:0]; read returns 0.
//  MMIO +0x4 STATUS read: {27'b0, count[2:0] saturated at 7, empty, full}; bit0=full, bit1=empty.
//  Other MMIO offsets and unmapped addresses: read 0; writes ignored; never stall.
//  d_data_out = 0 when d_read_en=0.
//  Both strobes in the same cycle: write performed and read data driven from pre-write contents.
//  FIFO: push = d_write_en && TXDATA && !pstop_o; pop = tx_valid && tx_ready.
//  Count width $clog2(TX_DEPTH)+1.
//  Push and pop in the same cycle: count unchanged, both pointers advance.
//  pstop_o = d_write_en && TXDATA && full && !pop.
//  A pop in the same cycle as a full-FIFO write accepts the write with no stall.
//  While pstop_o=1 the MEM stage holds its inputs. The push completes on the first cycle pstop_o drops.
//  Exactly one byte is pushed per stalled store.
//  Pointers wrap modulo TX_DEPTH. tx_data/tx_valid depend only on registered FIFO state.
//  Reset values: count=0, pointers=0, tx_valid=0, tx_data=0 (head entry cleared), pstop_o=0 (count 0), align_err_o=0.
//  Reset mid-operation flushes all queued bytes. A byte presented with tx_valid is dropped even if tx_ready was high.
//  Reset has priority over push/pop in the same cycle.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined:
//   - any access (read or write) with d_addr[1:0]!=0 is suppressed: no RAM write, no push, no stall, d_data_out=0.
//   - align_err_o is registered and pulses 1 for one cycle after the access.
//  Not defined:
//   - the align_err_o port is absent and d_addr[1:0] is ignored (word access at d_addr & ~3).
// TESTING
//  T1 write 0xDEADBEEF @0x10, next cycle read @0x10 -> d_data_out=0xDEADBEEF; read @0x14 unwritten -> X-free after bench init.
//  T2 tx_ready=0; write TXDATA 0x41,0x42,0x43,0x44 -> STATUS=0x11 (count 4, full=1).
//     5th write 0x45 -> pstop_o=1 held; raise tx_ready -> 0x41 pops, 0x45 pushed same cycle, pstop_o=0.
//  T3 drain with tx_ready=1 -> tx_data sequence 0x41,0x42,0x43,0x44,0x45, then tx_valid=0 and STATUS=0x02.
//  T4 fill FIFO to 3, assert rst for 1 cycle mid-drain -> tx_valid=0, STATUS=0x02, RAM word @0x10 still 0xDEADBEEF.
//  T5 read @0x8000_0000 and write there -> d_data_out=0, no RAM change, pstop_o=0.
//     Simultaneous read+write @0x20 -> d_data_out = old value.
//  T6 (DMEM_ALIGN_CHECK_EN) write @0x12 -> RAM unchanged, align_err_o=1 next cycle only.
//     Without macro the same write lands at 0x10.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data responder with word RAM and memory-mapped UART TX FIFO.
// Loads are combinational (same-cycle d_data_out); FIFO head/valid come from registered state.
// A TXDATA store into a full FIFO raises pstop_o until a pop frees a slot.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (suppress misaligned accesses, adds align_err_o).
module dmem_responder #(
  parameter int          RAM_AW    = 10,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int          TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_read_en,
  input  logic        d_write_en,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_write_data,
  output logic [31:0] d_data_out,
  output logic        pstop_o,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        align_err_o
`endif
);

  localparam int PW        = $clog2(TX_DEPTH);
  localparam int CW        = PW + 1;
  localparam int RAM_WORDS = 2 ** RAM_AW;

  logic [31:0]       ram [RAM_WORDS];
  logic [7:0]        fifo [TX_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_sel;
  logic              mmio_sel;
  logic              txdata_sel;
  logic              status_sel;
  logic              aligned;
  logic              txdata_wr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [2:0]        count_sat;
  logic [31:0]       status_word;

  // Address decode: RAM occupies the bottom of the map, MMIO is a 64 KiB window
  assign ram_sel    = (d_addr[31:RAM_AW+2] == '0);
  assign mmio_sel   = (d_addr[31:16] == MMIO_BASE[31:16]);
  assign txdata_sel = mmio_sel && (d_addr[15:2] == 14'd0);
  assign status_sel = mmio_sel && (d_addr[15:2] == 14'd1);
  assign ram_idx    = d_addr[RAM_AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign aligned = (d_addr[1:0] == 2'b00);
`else
  // Byte offset within the word is ignored: every access is a word access
  logic unused_addr_lsb;
  assign aligned         = 1'b1;
  assign unused_addr_lsb = ^d_addr[1:0];
`endif

  // FIFO handshake; a pop in the same cycle lets a full-FIFO store through
  assign full      = (count == CW'(TX_DEPTH));
  assign empty     = (count == '0);
  assign tx_valid  = !empty;
  assign tx_data   = fifo[rd_ptr];
  assign pop       = tx_valid && tx_ready;
  assign txdata_wr = d_write_en && txdata_sel && aligned;
  assign pstop_o   = txdata_wr && full && !pop;
  assign push      = txdata_wr && !pstop_o;

  // STATUS count field saturates at 7 so deep FIFOs still fit in three bits
  always_comb begin
    count_sat = 3'd7;
    if (32'(count) < 32'd7) count_sat = 3'(count);
  end

  assign status_word = {27'b0, count_sat, empty, full};

  // Load mux; RAM read is asynchronous so a same-cycle store returns old data
  always_comb begin
    d_data_out = '0;
    if (d_read_en && aligned) begin
      if (ram_sel)         d_data_out = ram[ram_idx];
      else if (status_sel) d_data_out = status_word;
    end
  end

  // Word RAM store port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (d_write_en && ram_sel && aligned) ram[ram_idx] <= d_write_data;
  end

  // TX FIFO state; reset flushes queued bytes and clears the head entry
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < TX_DEPTH; i++) fifo[i] <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= d_write_data[7:0];
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  // One-cycle pulse after any misaligned read or write
  always_ff @(posedge clk) begin
    if (rst) align_err_o <= 1'b0;
    else     align_err_o <= (d_read_en || d_write_en) && !aligned;
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table for the named scenarios,
// hand sequence for the misaligned store, then randomized traffic vs. a queue/array model.
module tb_dmem_responder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] TX    = 32'hFFFF_0000;
  localparam logic [31:0] ST    = 32'hFFFF_0004;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_read_en;
  logic        d_write_en;
  logic [31:0] d_addr;
  logic [31:0] d_write_data;
  logic [31:0] d_data_out;
  logic        pstop_o;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        align_err_o;
`endif

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .d_read_en    (d_read_en),
    .d_write_en   (d_write_en),
    .d_addr       (d_addr),
    .d_write_data (d_write_data),
    .d_data_out   (d_data_out),
    .pstop_o      (pstop_o),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    .align_err_o  (align_err_o)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] ram_m [1024];
  logic [7:0]  q [$];
  logic        align_m = 1'b0;
  logic        mchk = 1'b0;
  logic        last_stall = 1'b0;

  // Samples taken at the negative edge
  logic [31:0] s_do;
  logic        s_stop;
  logic        s_vld;
  logic [7:0]  s_txd;
  logic        s_al;

  typedef struct {
    string       name;
    logic        r;
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic        rdy;
    logic [31:0] edo;
    logic        estop;
    logic        evld;
    logic [7:0]  etxd;
    logic        tcare;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic m_aligned(logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return a[1:0] == 2'b00;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic m_is_tx(logic [31:0] a);
    return (a[31:16] == 16'hFFFF) && (a[15:2] == 14'd0);
  endfunction

  function automatic logic [31:0] m_status();
    int n = q.size();
    logic [2:0] c = (n > 7) ? 3'd7 : 3'(n);
    return {27'b0, c, n == 0, n == DEPTH};
  endfunction

  function automatic logic [31:0] m_rdata(logic rd, logic [31:0] a);
    if (!rd || !m_aligned(a)) return 32'h0;
    if (a < 32'd4096) return ram_m[a[11:2]];
    if (a[31:16] == 16'hFFFF && a[15:2] == 14'd1) return m_status();
    return 32'h0;
  endfunction

  function automatic logic m_stall(logic wr, logic [31:0] a, logic rdy);
    return wr && m_aligned(a) && m_is_tx(a) && (q.size() == DEPTH) && !rdy;
  endfunction

  // One clock: drive after the rising edge, sample on the falling edge, advance the model
  task automatic cycle(input logic r, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    logic e_stop;
    logic e_pop;
    rst = r; d_read_en = rd; d_write_en = wr; d_addr = a; d_write_data = wd; tx_ready = rdy;
    @(negedge clk);
    s_do = d_data_out; s_stop = pstop_o; s_vld = tx_valid; s_txd = tx_data;
`ifdef DMEM_ALIGN_CHECK_EN
    s_al = align_err_o;
`else
    s_al = 1'b0;
`endif
    e_stop = m_stall(wr, a, rdy);
    if (mchk) begin
      check("rand_data", s_do, m_rdata(rd, a));
      check("rand_stall", 32'(s_stop), 32'(e_stop));
      check("rand_valid", 32'(s_vld), 32'(q.size() != 0));
      if (q.size() != 0) check("rand_txdata", 32'(s_txd), 32'(q[0]));
`ifdef DMEM_ALIGN_CHECK_EN
      check("rand_align", 32'(s_al), 32'(align_m));
`endif
    end
    last_stall = e_stop;
    @(posedge clk);
    if (r) begin
      q.delete();
      align_m = 1'b0;
    end else begin
      e_pop = (q.size() != 0) && rdy;
      if (wr && m_aligned(a) && a < 32'd4096) ram_m[a[11:2]] = wd;
      if (e_pop) void'(q.pop_front());
      if (wr && m_aligned(a) && m_is_tx(a) && !e_stop) q.push_back(wd[7:0]);
      align_m = (rd || wr) && !m_aligned(a);
    end
    #1;
  endtask

  function automatic vec_t mk(string nm, logic r, logic rd, logic wr, logic [31:0] a,
                              logic [31:0] wd, logic rdy, logic [31:0] edo, logic estop,
                              logic evld, logic [7:0] etxd, logic tcare);
    vec_t v;
    v.name = nm; v.r = r; v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.rdy = rdy;
    v.edo = edo; v.estop = estop; v.evld = evld; v.etxd = etxd; v.tcare = tcare;
    return v;
  endfunction

  initial begin
    logic        r;
    logic        h_rd;
    logic        h_wr;
    logic [31:0] h_a;
    logic [31:0] h_wd;
    logic        rdy;

    // Directed table: name, rst, rd, wr, addr, wdata, tx_ready, exp data, exp stall, exp valid, exp tx_data, tx_data checked
    vecs.push_back(mk("t1_wr",         0,0,1,32'h10,32'hDEADBEEF,0, 32'h0,       0,0,8'h00,0));
    vecs.push_back(mk("t1_rd",         0,1,0,32'h10,32'h0,       0, 32'hDEADBEEF,0,0,8'h00,0));
    vecs.push_back(mk("t1_rd_unwr",    0,1,0,32'h14,32'h0,       0, 32'h10000005,0,0,8'h00,0));
    vecs.push_back(mk("t2_push41",     0,0,1,TX,    32'h41,      0, 32'h0,       0,0,8'h00,0));
    vecs.push_back(mk("t2_push42",     0,0,1,TX,    32'h42,      0, 32'h0,       0,1,8'h41,1));
    vecs.push_back(mk("t2_push43",     0,0,1,TX,    32'h43,      0, 32'h0,       0,1,8'h41,1));
    vecs.push_back(mk("t2_push44",     0,0,1,TX,    32'h44,      0, 32'h0,       0,1,8'h41,1));
    vecs.push_back(mk("t2_rd_txdata",  0,1,0,TX,    32'h0,       0, 32'h0,       0,1,8'h41,1));
    vecs.push_back(mk("t2_status_full",0,1,0,ST,    32'h0,       0, 32'h11,      0,1,8'h41,1));
    vecs.push_back(mk("t2_stall_a",    0,0,1,TX,    32'h45,      0, 32'h0,       1,1,8'h41,1));
    vecs.push_back(mk("t2_stall_b",    0,0,1,TX,    32'h45,      0, 32'h0,       1,1,8'h41,1));
    vecs.push_back(mk("t2_release",    0,0,1,TX,    32'h45,      1, 32'h0,       0,1,8'h41,1));
    vecs.push_back(mk("t2_status_rel", 0,1,0,ST,    32'h0,       0, 32'h11,      0,1,8'h42,1));
    vecs.push_back(mk("t3_pop42",      0,0,0,32'h0, 32'h0,       1, 32'h0,       0,1,8'h42,1));
    vecs.push_back(mk("t3_pop43",      0,0,0,32'h0, 32'h0,       1, 32'h0,       0,1,8'h43,1));
    vecs.push_back(mk("t3_pop44",      0,0,0,32'h0, 32'h0,       1, 32'h0,       0,1,8'h44,1));
    vecs.push_back(mk("t3_pop45",      0,0,0,32'h0, 32'h0,       1, 32'h0,       0,1,8'h45,1));
    vecs.push_back(mk("t3_status_emp", 0,1,0,ST,    32'h0,       1, 32'h02,      0,0,8'h00,0));
    vecs.push_back(mk("t4_push51",     0,0,1,TX,    32'h51,      0, 32'h0,       0,0,8'h00,0));
    vecs.push_back(mk("t4_push52",     0,0,1,TX,    32'h52,      0, 32'h0,       0,1,8'h51,1));
    vecs.push_back(mk("t4_push53",     0,0,1,TX,    32'h53,      0, 32'h0,       0,1,8'h51,1));
    vecs.push_back(mk("t4_pop51",      0,0,0,32'h0, 32'h0,       1, 32'h0,       0,1,8'h51,1));
    vecs.push_back(mk("t4_reset",      1,0,0,32'h0, 32'h0,       1, 32'h0,       0,1,8'h52,1));
    vecs.push_back(mk("t4_status",     0,1,0,ST,    32'h0,       1, 32'h02,      0,0,8'h00,1));
    vecs.push_back(mk("t4_ram_kept",   0,1,0,32'h10,32'h0,       0, 32'hDEADBEEF,0,0,8'h00,0));
    vecs.push_back(mk("t5_rd_unmap",   0,1,0,32'h80000000,32'h0, 0, 32'h0,       0,0,8'h00,0));
    vecs.push_back(mk("t5_wr_unmap",   0,0,1,32'h80000000,32'hCAFEF00D,0,32'h0,  0,0,8'h00,0));
    vecs.push_back(mk("t5_rd_word0",   0,1,0,32'h0, 32'h0,       0, 32'h10000000,0,0,8'h00,0));
    vecs.push_back(mk("t5_wr_mmio8",   0,0,1,32'hFFFF0008,32'h77,0, 32'h0,       0,0,8'h00,0));
    vecs.push_back(mk("t5_wr_near",    0,0,1,32'hFFFE0000,32'h99,0, 32'h0,       0,0,8'h00,0));
    vecs.push_back(mk("t5_status",     0,1,0,ST,    32'h0,       0, 32'h02,      0,0,8'h00,0));
    vecs.push_back(mk("t5_rdwr_same",  0,1,1,32'h20,32'h12345678,0, 32'h10000008,0,0,8'h00,0));
    vecs.push_back(mk("t5_rd_after",   0,1,0,32'h20,32'h0,       0, 32'h12345678,0,0,8'h00,0));

    // Reset state
    #1;
    cycle(1, 0, 0, 32'h0, 32'h0, 0);
    cycle(1, 0, 0, 32'h0, 32'h0, 0);
    check("rst_data", s_do, 32'h0);
    check("rst_stall", 32'(s_stop), 32'h0);
    check("rst_valid", 32'(s_vld), 32'h0);
    check("rst_txdata", 32'(s_txd), 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
    check("rst_align", 32'(s_al), 32'h0);
`endif

    // Bench init of the low RAM words used by every later test
    for (int i = 0; i < 32; i++) cycle(0, 0, 1, 32'(i) << 2, 32'h1000_0000 + 32'(i), 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].rdy);
      check($sformatf("%s_data", vecs[i].name), s_do, vecs[i].edo);
      check($sformatf("%s_stall", vecs[i].name), 32'(s_stop), 32'(vecs[i].estop));
      check($sformatf("%s_valid", vecs[i].name), 32'(s_vld), 32'(vecs[i].evld));
      if (vecs[i].tcare) check($sformatf("%s_txdata", vecs[i].name), 32'(s_txd), 32'(vecs[i].etxd));
    end

    // Misaligned store to 0x12
    cycle(0, 0, 1, 32'h12, 32'hAAAA5555, 0);
    check("t6_stall", 32'(s_stop), 32'h0);
    cycle(0, 1, 0, 32'h10, 32'h0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    check("t6_ram_unchanged", s_do, 32'hDEADBEEF);
    check("t6_align_pulse", 32'(s_al), 32'h1);
    cycle(0, 0, 0, 32'h0, 32'h0, 0);
    check("t6_align_clear", 32'(s_al), 32'h0);
`else
    check("t6_word_write", s_do, 32'hAAAA5555);
`endif

    // Randomized traffic against the model; a stalled store is held until accepted
    mchk = 1'b1;
    h_rd = 1'b0; h_wr = 1'b0; h_a = 32'h0; h_wd = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) == 0);
      if (!last_stall || r) begin
        case ($urandom_range(0, 5))
          0, 1:    h_a = 32'($urandom_range(0, 31)) << 2;
          2, 3:    h_a = TX;
          4:       h_a = ST;
          default: h_a = ($urandom_range(0, 1) != 0) ? 32'hFFFF0008
                                                      : 32'h8000_0000 + (32'($urandom_range(0, 255)) << 2);
        endcase
        h_rd = 1'($urandom_range(0, 1));
        h_wr = r ? 1'b0 : 1'($urandom_range(0, 1));
        h_wd = $urandom;
      end
      rdy = ($urandom_range(0, 2) == 0);
      cycle(r, h_rd, h_wr, h_a, h_wd, rdy);
    end
    mchk = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
